// File: rtl/arbitro_turni.sv
// arbitro_turni: two-player turn arbiter in front of a round/game engine.
// It collects one move per player, presents both moves to the engine for one
// cycle, then waits for the round result and the optional game result.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   avvia, cfg_turni      start/restart request, game-length code for engine
//   p1_valid/mossa/ready  player 1 move handshake (move 00 is not stored)
//   p2_valid/mossa/ready  player 2 move handshake (move 00 is not stored)
//   primo_out/secondo_out moves to engine (carry cfg_turni during setup)
//   inizia_out            engine setup strobe, high for the whole setup phase
//   manche_in/partita_in  engine round result / game result
//   esito_valid/manche    one-cycle round result (00 = no engine answer)
//   partita_fine/esito    one-cycle game-over strobe, result held until avvia
//   occupato, num_manche  game in progress, rounds presented (saturating)
// Optional feature: define ARBITRO_TURNI_TIMEOUT_EN to end the game when a
// player leaves its slot empty for 255 collection cycles.
module arbitro_turni (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       avvia,
    input  logic [3:0] cfg_turni,
    input  logic       p1_valid,
    input  logic [1:0] p1_mossa,
    output logic       p1_ready,
    input  logic       p2_valid,
    input  logic [1:0] p2_mossa,
    output logic       p2_ready,
    output logic [1:0] primo_out,
    output logic [1:0] secondo_out,
    output logic       inizia_out,
    input  logic [1:0] manche_in,
    input  logic [1:0] partita_in,
    output logic       esito_valid,
    output logic [1:0] esito_manche,
    output logic       partita_fine,
    output logic [1:0] partita_esito,
    output logic       occupato,
    output logic [4:0] num_manche
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        RACCOLTA,
        INVIO,
        ATTESA
    } stato_t;

    stato_t     stato;
    logic [1:0] slot1;
    logic [1:0] slot2;
    logic [1:0] attesaCnt;
    logic [1:0] partitaVista;

    logic       hs1;
    logic       hs2;
    logic [1:0] slot1Nxt;
    logic [1:0] slot2Nxt;
    logic       entrambi;
    logic [1:0] partitaOra;
    logic       fineAttesa;

`ifdef ARBITRO_TURNI_TIMEOUT_EN
    logic [7:0] raccoltaCnt;
`endif

    // A slot is empty when it holds 00; legal stored moves are never 00.
    assign hs1      = p1_valid & p1_ready;
    assign hs2      = p2_valid & p2_ready;
    assign slot1Nxt = (hs1 && p1_mossa != 2'b00) ? p1_mossa : slot1;
    assign slot2Nxt = (hs2 && p2_mossa != 2'b00) ? p2_mossa : slot2;
    assign entrambi = (slot1Nxt != 2'b00) && (slot2Nxt != 2'b00);

    // First nonzero game result seen during this wait wins.
    assign partitaOra = (partitaVista != 2'b00) ? partitaVista : partita_in;
    assign fineAttesa = (manche_in != 2'b00) || (attesaCnt == 2'd3);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stato         <= IDLE;
            slot1         <= 2'b00;
            slot2         <= 2'b00;
            attesaCnt     <= 2'd0;
            partitaVista  <= 2'b00;
            p1_ready      <= 1'b0;
            p2_ready      <= 1'b0;
            primo_out     <= 2'b00;
            secondo_out   <= 2'b00;
            inizia_out    <= 1'b0;
            esito_valid   <= 1'b0;
            esito_manche  <= 2'b00;
            partita_fine  <= 1'b0;
            partita_esito <= 2'b00;
            occupato      <= 1'b0;
            num_manche    <= 5'd0;
`ifdef ARBITRO_TURNI_TIMEOUT_EN
            raccoltaCnt   <= 8'd0;
`endif
        end else begin
            inizia_out   <= 1'b0;
            primo_out    <= 2'b00;
            secondo_out  <= 2'b00;
            p1_ready     <= 1'b0;
            p2_ready     <= 1'b0;
            esito_valid  <= 1'b0;
            esito_manche <= 2'b00;
            partita_fine <= 1'b0;
            occupato     <= 1'b1;

            if (avvia) begin
                // Start or abort: any pending move or result is dropped.
                stato         <= SETUP;
                inizia_out    <= 1'b1;
                slot1         <= 2'b00;
                slot2         <= 2'b00;
                partita_esito <= 2'b00;
                if (stato == SETUP) begin
                    primo_out   <= primo_out;
                    secondo_out <= secondo_out;
                end else begin
                    {primo_out, secondo_out} <= cfg_turni;
                end
            end else begin
                unique case (stato)
                    IDLE: begin
                        occupato <= 1'b0;
                    end
                    SETUP: begin
                        stato      <= RACCOLTA;
                        num_manche <= 5'd0;
                        slot1      <= 2'b00;
                        slot2      <= 2'b00;
                        p1_ready   <= 1'b1;
                        p2_ready   <= 1'b1;
`ifdef ARBITRO_TURNI_TIMEOUT_EN
                        raccoltaCnt <= 8'd0;
`endif
                    end
                    RACCOLTA: begin
                        slot1 <= slot1Nxt;
                        slot2 <= slot2Nxt;
                        if (entrambi) begin
                            stato       <= INVIO;
                            primo_out   <= slot1Nxt;
                            secondo_out <= slot2Nxt;
                            if (num_manche != 5'd31)
                                num_manche <= num_manche + 5'd1;
                        end
`ifdef ARBITRO_TURNI_TIMEOUT_EN
                        else if (raccoltaCnt == 8'd255) begin
                            // The player still missing loses; 11 if both.
                            stato         <= IDLE;
                            occupato      <= 1'b0;
                            partita_fine  <= 1'b1;
                            partita_esito <= {slot1Nxt == 2'b00,
                                              slot2Nxt == 2'b00};
                            slot1         <= 2'b00;
                            slot2         <= 2'b00;
                        end
`endif
                        else begin
                            p1_ready <= (slot1Nxt == 2'b00);
                            p2_ready <= (slot2Nxt == 2'b00);
`ifdef ARBITRO_TURNI_TIMEOUT_EN
                            raccoltaCnt <= raccoltaCnt + 8'd1;
`endif
                        end
                    end
                    INVIO: begin
                        stato        <= ATTESA;
                        attesaCnt    <= 2'd0;
                        partitaVista <= 2'b00;
                    end
                    ATTESA: begin
                        if (fineAttesa) begin
                            esito_valid  <= 1'b1;
                            esito_manche <= manche_in;
                            slot1        <= 2'b00;
                            slot2        <= 2'b00;
                            if (partitaOra != 2'b00) begin
                                stato         <= IDLE;
                                occupato      <= 1'b0;
                                partita_fine  <= 1'b1;
                                partita_esito <= partitaOra;
                            end else begin
                                stato    <= RACCOLTA;
                                p1_ready <= 1'b1;
                                p2_ready <= 1'b1;
`ifdef ARBITRO_TURNI_TIMEOUT_EN
                                raccoltaCnt <= 8'd0;
`endif
                            end
                        end else begin
                            attesaCnt    <= attesaCnt + 2'd1;
                            partitaVista <= partitaOra;
                        end
                    end
                    default: begin
                        stato    <= IDLE;
                        occupato <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_arbitro_turni.sv
// Testbench for arbitro_turni: directed scenarios plus randomized traffic,
// every cycle compared against a phase-level behavioural model.
module tb_arbitro_turni;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       avvia = 1'b0;
    logic [3:0] cfg_turni = 4'd0;
    logic       p1_valid = 1'b0;
    logic [1:0] p1_mossa = 2'd0;
    logic       p1_ready;
    logic       p2_valid = 1'b0;
    logic [1:0] p2_mossa = 2'd0;
    logic       p2_ready;
    logic [1:0] primo_out;
    logic [1:0] secondo_out;
    logic       inizia_out;
    logic [1:0] manche_in = 2'd0;
    logic [1:0] partita_in = 2'd0;
    logic       esito_valid;
    logic [1:0] esito_manche;
    logic       partita_fine;
    logic [1:0] partita_esito;
    logic       occupato;
    logic [4:0] num_manche;

    always #5 clk = ~clk;

    arbitro_turni dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .avvia        (avvia),
        .cfg_turni    (cfg_turni),
        .p1_valid     (p1_valid),
        .p1_mossa     (p1_mossa),
        .p1_ready     (p1_ready),
        .p2_valid     (p2_valid),
        .p2_mossa     (p2_mossa),
        .p2_ready     (p2_ready),
        .primo_out    (primo_out),
        .secondo_out  (secondo_out),
        .inizia_out   (inizia_out),
        .manche_in    (manche_in),
        .partita_in   (partita_in),
        .esito_valid  (esito_valid),
        .esito_manche (esito_manche),
        .partita_fine (partita_fine),
        .partita_esito(partita_esito),
        .occupato     (occupato),
        .num_manche   (num_manche)
    );

`ifdef ARBITRO_TURNI_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    int nTests = 0;
    int nFail  = 0;

    // Behavioural model: game phase plus slot contents and counters.
    localparam int P_IDLE = 0;
    localparam int P_SETUP = 1;
    localparam int P_COLL = 2;
    localparam int P_SEND = 3;
    localparam int P_WAIT = 4;

    int       ph = P_IDLE;
    int       s1 = 0;
    int       s2 = 0;
    int       nm = 0;
    int       pe = 0;
    int       waited = 0;
    int       pseen = 0;
    int       coll = 0;
    bit [3:0] cfgHold = 4'd0;
    bit       eFine = 1'b0;
    bit       eEsV = 1'b0;
    int       eEsM = 0;

    task automatic modelStep();
        eFine = 1'b0;
        eEsV  = 1'b0;
        eEsM  = 0;
        if (!rst_n) begin
            ph = P_IDLE; s1 = 0; s2 = 0; nm = 0; pe = 0;
        end else if (avvia) begin
            if (ph != P_SETUP) cfgHold = cfg_turni;
            ph = P_SETUP; s1 = 0; s2 = 0; pe = 0;
        end else begin
            case (ph)
                P_SETUP: begin
                    ph = P_COLL; nm = 0; s1 = 0; s2 = 0; coll = 0;
                end
                P_COLL: begin
                    if (p1_valid && s1 == 0 && p1_mossa != 0) s1 = p1_mossa;
                    if (p2_valid && s2 == 0 && p2_mossa != 0) s2 = p2_mossa;
                    if (s1 != 0 && s2 != 0) begin
                        ph = P_SEND;
                        nm = (nm < 31) ? nm + 1 : 31;
                    end else if (TO_EN && coll == 255) begin
                        eFine = 1'b1;
                        pe = ((s1 == 0) ? 2 : 0) + ((s2 == 0) ? 1 : 0);
                        s1 = 0; s2 = 0; ph = P_IDLE;
                    end else begin
                        coll++;
                    end
                end
                P_SEND: begin
                    ph = P_WAIT; waited = 0; pseen = 0;
                end
                P_WAIT: begin
                    if (pseen == 0) pseen = partita_in;
                    if (manche_in != 0 || waited == 3) begin
                        eEsV = 1'b1; eEsM = manche_in; s1 = 0; s2 = 0;
                        if (pseen != 0) begin
                            eFine = 1'b1; pe = pseen; ph = P_IDLE;
                        end else begin
                            ph = P_COLL; coll = 0;
                        end
                    end else begin
                        waited++;
                    end
                end
                default: ;
            endcase
        end
    endtask

    function automatic logic [18:0] expVec();
        logic [1:0] pr;
        logic [1:0] se;
        logic [1:0] m1;
        logic [1:0] m2;
        logic [1:0] em;
        logic [1:0] pv;
        logic [4:0] n5;
        pr = 2'd0; se = 2'd0;
        m1 = s1[1:0]; m2 = s2[1:0];
        em = eEsM[1:0]; pv = pe[1:0]; n5 = nm[4:0];
        if (ph == P_SETUP) begin
            pr = cfgHold[3:2]; se = cfgHold[1:0];
        end else if (ph == P_SEND) begin
            pr = m1; se = m2;
        end
        return {ph == P_COLL && s1 == 0, ph == P_COLL && s2 == 0, pr, se,
                ph == P_SETUP, eEsV, em, eFine, pv, ph != P_IDLE, n5};
    endfunction

    function automatic logic [18:0] actVec();
        return {p1_ready, p2_ready, primo_out, secondo_out, inizia_out,
                esito_valid, esito_manche, partita_fine, partita_esito,
                occupato, num_manche};
    endfunction

    // Compare process: model advances on each edge, outputs checked 1ns later.
    always @(posedge clk) begin
        modelStep();
        #1;
        nTests++;
        if (actVec() !== expVec()) begin
            nFail++;
            $display("FAIL cycle_model t=%0t actual=%h expected=%h",
                     $time, actVec(), expVec());
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    int n;

    initial begin
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_occupato", occupato, 0);
        chk("rst_num", num_manche, 0);
        chk("rst_inizia", inizia_out, 0);
        chk("rst_ready", {p1_ready, p2_ready}, 0);
        rst_n = 1'b1;
        tick();

        // Setup with cfg 0110 for one cycle.
        avvia = 1'b1; cfg_turni = 4'b0110;
        tick();
        chk("setup_inizia", inizia_out, 1);
        chk("setup_primo", primo_out, 2'b01);
        chk("setup_secondo", secondo_out, 2'b10);
        avvia = 1'b0;
        tick();
        chk("racc_inizia", inizia_out, 0);
        chk("racc_ready", {p1_ready, p2_ready}, 2'b11);
        chk("racc_primo", primo_out, 0);

        // Simultaneous moves 01/11, engine answers 01.
        p1_valid = 1'b1; p1_mossa = 2'b01;
        p2_valid = 1'b1; p2_mossa = 2'b11;
        tick();
        chk("invio_primo", primo_out, 2'b01);
        chk("invio_secondo", secondo_out, 2'b11);
        chk("invio_num", num_manche, 1);
        p1_valid = 1'b0; p2_valid = 1'b0; manche_in = 2'b01;
        tick();
        tick();
        chk("esito_valid", esito_valid, 1);
        chk("esito_manche", esito_manche, 2'b01);
        chk("esito_num", num_manche, 1);
        manche_in = 2'b00;

        // Move 00 is consumed but not stored.
        p1_valid = 1'b1; p1_mossa = 2'b00;
        tick();
        chk("zero_p1_ready", p1_ready, 1);
        p1_mossa = 2'b10; p2_valid = 1'b1; p2_mossa = 2'b01;
        tick();
        chk("zero_primo", primo_out, 2'b10);
        chk("zero_num", num_manche, 2);
        p1_valid = 1'b0; p2_valid = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!esito_valid && n < 10);
        chk("noanswer_len", n, 5);
        chk("noanswer_esito", esito_manche, 0);

        // Game over with partita 10.
        p1_valid = 1'b1; p1_mossa = 2'b11;
        p2_valid = 1'b1; p2_mossa = 2'b11;
        tick();
        p1_valid = 1'b0; p2_valid = 1'b0;
        manche_in = 2'b11; partita_in = 2'b10;
        tick();
        tick();
        chk("go_fine", partita_fine, 1);
        chk("go_esito", partita_esito, 2'b10);
        chk("go_manche", esito_manche, 2'b11);
        chk("go_occupato", occupato, 0);
        manche_in = 2'b00; partita_in = 2'b00;
        tick();
        chk("go_fine_pulse", partita_fine, 0);
        chk("go_esito_held", partita_esito, 2'b10);

        // Abort: avvia beats a simultaneous handshake.
        avvia = 1'b1; cfg_turni = 4'b1001;
        tick();
        chk("pesito_clear", partita_esito, 0);
        avvia = 1'b0;
        tick();
        p1_valid = 1'b1; p1_mossa = 2'b10; avvia = 1'b1;
        tick();
        chk("abort_inizia", inizia_out, 1);
        chk("abort_primo", primo_out, 2'b10);
        chk("abort_noesito", esito_valid, 0);
        avvia = 1'b0; p1_valid = 1'b0;
        tick();
        tick();
        chk("abort_discard", p1_ready, 1);

        // Many quick rounds: counter saturates at 31.
        p1_valid = 1'b1; p1_mossa = 2'b01;
        p2_valid = 1'b1; p2_mossa = 2'b01;
        manche_in = 2'b01;
        repeat (120) tick();
        chk("num_saturate", num_manche, 31);
        p1_valid = 1'b0; p2_valid = 1'b0; manche_in = 2'b00;

        // Reset in the middle of the wait phase.
        avvia = 1'b1;
        tick();
        avvia = 1'b0;
        tick();
        p1_valid = 1'b1; p2_valid = 1'b1;
        tick();
        p1_valid = 1'b0; p2_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_occ", occupato, 0);
        chk("midrst_num", num_manche, 0);
        chk("midrst_strobes", {esito_valid, partita_fine}, 0);
        rst_n = 1'b1;
        tick();

        // Only player 2 ever moves.
        avvia = 1'b1;
        tick();
        avvia = 1'b0;
        tick();
        p2_valid = 1'b1; p2_mossa = 2'b10;
        tick();
        p2_valid = 1'b0;
        if (TO_EN) begin
            n = 0;
            while (!partita_fine && n < 400) begin
                tick();
                n++;
            end
            chk("to_fine", partita_fine, 1);
            chk("to_esito", partita_esito, 2'b10);
            chk("to_occ", occupato, 0);
        end else begin
            repeat (1000) tick();
            chk("wait_occ", occupato, 1);
            chk("wait_ready", {p1_ready, p2_ready}, 2'b10);
        end

        // Randomized traffic, checked only by the model.
        for (int i = 0; i < 3000; i++) begin
            rst_n      = ($urandom_range(0, 199) != 0);
            avvia      = ($urandom_range(0, 63) == 0);
            cfg_turni  = 4'($urandom_range(0, 15));
            p1_valid   = ($urandom_range(0, 1) == 1);
            p1_mossa   = 2'($urandom_range(0, 3));
            p2_valid   = ($urandom_range(0, 1) == 1);
            p2_mossa   = 2'($urandom_range(0, 3));
            manche_in  = ($urandom_range(0, 9) < 3) ?
                         2'($urandom_range(1, 3)) : 2'b00;
            partita_in = ($urandom_range(0, 19) < 3) ?
                         2'($urandom_range(1, 3)) : 2'b00;
            tick();
        end
        rst_n = 1'b1; avvia = 1'b0; p1_valid = 1'b0; p2_valid = 1'b0;
        manche_in = 2'b00; partita_in = 2'b00;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/arbitro_turni.md
ARBITRO_TURNI -- requirements
Module: arbitro_turni

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  synchronous active-low reset.
REQ-002 The block SHALL have these player ports: avvia  input  1  start/restart game request; cfg_turni  input  4  game-length code placed on the engine at setup; p1_valid  input  1  player 1 move offered; p1_mossa  input  2  player 1 move; p1_ready  output  1  player 1 slot empty; p2_valid  input  1  player 2 move offered; p2_mossa  input  2  player 2 move; p2_ready  output  1  player 2 slot empty.
REQ-003 The block SHALL have these engine ports: primo_out  output  2  move to engine PRIMO; secondo_out  output  2  move to engine SECONDO; inizia_out  output  1  engine INIZIA; manche_in  input  2  engine MANCHE; partita_in  input  2  engine PARTITA.
REQ-004 The block SHALL have these status ports: esito_valid  output  1  one-cycle round-result strobe; esito_manche  output  2  round result (01 P1, 10 P2, 11 draw, 00 rejected); partita_fine  output  1  one-cycle game-over strobe; partita_esito  output  2  game result, held until next avvia; occupato  output  1  game in progress; num_manche  output  5  rounds presented since setup, saturating at 31.

Function
REQ-005 The FSM SHALL have states IDLE, SETUP, RACCOLTA, INVIO, ATTESA.
REQ-006 IDLE: primo_out = secondo_out = 00, inizia_out = 0, ready = 0, occupato = 0; avvia = 1 -> SETUP.
REQ-007 SETUP: inizia_out = 1, {primo_out, secondo_out} = cfg_turni as sampled on the avvia cycle; stays while avvia = 1; avvia = 0 -> RACCOLTA, num_manche cleared, both slots cleared.
REQ-008 RACCOLTA: px_ready = 1 when slot x empty; handshake = px_valid & px_ready; move 00 completes the handshake but is not stored; both players may handshake in the same cycle.
REQ-009 RACCOLTA -> INVIO in the cycle after both slots are full; primo_out/secondo_out = 00 in all states except SETUP and INVIO.
REQ-010 INVIO: exactly one cycle, primo_out = slot 1, secondo_out = slot 2, num_manche increments (saturating); -> ATTESA.
REQ-011 ATTESA: waits up to 4 cycles; first cycle with manche_in != 00 -> esito_valid = 1, esito_manche = manche_in; no nonzero manche_in in 4 cycles -> esito_valid = 1, esito_manche = 00.
REQ-012 On leaving ATTESA: both slots cleared; if partita_in != 00 sampled in ATTESA, partita_fine = 1 for one cycle, partita_esito = partita_in, -> IDLE; else -> RACCOLTA.
REQ-013 avvia = 1 in any non-IDLE state SHALL abort the game next cycle: -> SETUP, slots cleared, no esito_valid or partita_fine strobe.
REQ-014 avvia and a player handshake in the same RACCOLTA cycle: avvia wins, move discarded.
REQ-015 occupato = 1 in SETUP, RACCOLTA, INVIO, ATTESA.

Reset
REQ-016 rst_n = 0 at a rising clk edge SHALL force IDLE, clear both slots, num_manche = 0, partita_esito = 00, all strobes 0, regardless of state, including mid-round.
REQ-017 All outputs SHALL be registered; reset values: all zero.

Configuration
REQ-018 Macro ARBITRO_TURNI_TIMEOUT_EN SHALL, when defined, add an 8-bit counter cleared on each RACCOLTA entry, incrementing each RACCOLTA cycle.
REQ-019 With the macro, counter reaching 255 with a slot still empty: partita_fine = 1, partita_esito = 01 if only slot 1 full, 10 if only slot 2 full, 11 if both empty; -> IDLE.
REQ-020 Without the macro, RACCOLTA SHALL wait indefinitely and no counter SHALL exist.

Verification
REQ-021 Reset mid-ATTESA -> next cycle IDLE, occupato = 0, num_manche = 0, no strobes.
REQ-022 avvia 1 cycle, cfg_turni = 4'b0110 -> inizia_out = 1 for 1 cycle with primo_out = 01, secondo_out = 10; then RACCOLTA, p1_ready = p2_ready = 1.
REQ-023 P1 offers 01, P2 offers 11 same cycle; engine returns manche_in = 01 -> one INVIO cycle with 01/11, esito_valid with esito_manche = 01, num_manche = 1.
REQ-024 P1 offers 00 then 10 -> first handshake discarded, p1_ready stays 1, second stored; INVIO shows 10.
REQ-025 partita_in = 10 during ATTESA -> partita_fine pulse, partita_esito = 10 held, state IDLE.
REQ-026 With ARBITRO_TURNI_TIMEOUT_EN, only P2 submits, 255 RACCOLTA cycles elapse -> partita_fine, partita_esito = 10; without macro -> still RACCOLTA after 1000 cycles.
